// File: rtl/bool_vector_tx.sv
// Boolean truth-table transmitter: sweeps (a,b) = 00..11 REPEAT times over a
// valid/ready channel, carrying the expected AND/OR/NOT results with each vector.
module bool_vector_tx #(
   parameter int REPEAT = 2,
   parameter int GAP    = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        a,
   output logic        b,
   output logic        exp_and,
   output logic        exp_or,
   output logic        exp_not_a,
   output logic [1:0]  vec_idx,
   output logic [15:0] sent_cnt,
   output logic        busy,
   output logic        done
);

   // state  | meaning
   // S_IDLE | waiting for start after reset
   // S_SEND | vector presented, out_valid high until accepted
   // S_GAP  | idle spacing after an accepted vector, gap timer running
   // S_DONE | run finished, last vector held, start restarts
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   localparam int LAST_SWEEP = (REPEAT > 0) ? REPEAT - 1 : 0;
   localparam int SW_W       = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam int GW         = (GAP > 1) ? $clog2(GAP + 1) : 1;

   localparam logic [SW_W-1:0] SWEEP_LAST = SW_W'(LAST_SWEEP);
   localparam logic [SW_W-1:0] SW_ONE     = SW_W'(1);
   localparam logic [GW-1:0]   GAP_LOAD   = GW'(GAP);
   localparam logic [GW-1:0]   GAP_ONE    = GW'(1);
   localparam logic            SEND_ANY   = (REPEAT > 0);
   localparam logic            USE_GAP    = (GAP > 0);

   state_t          r_state;
   state_t          w_next;
   logic            w_xfer;
   logic            w_last;
   logic            w_load0;
   logic            w_clr_cnt;
   logic            w_adv;
   logic            w_gap_load;
   logic            w_gap_tc;
   logic [1:0]      w_vec_nxt;

   logic [SW_W-1:0] r_sweep;
   logic [GW-1:0]   r_gap_cnt;
   logic [1:0]      r_vec_idx;
   logic            r_a;
   logic            r_b;
   logic            r_exp_and;
   logic            r_exp_or;
   logic            r_exp_not_a;
   logic [15:0]     r_sent_cnt;

   assign w_xfer    = (r_state == S_SEND) && out_ready;
   assign w_last    = (r_vec_idx == 2'd3) && (r_sweep == SWEEP_LAST);
   assign w_gap_tc  = (r_gap_cnt == GAP_ONE);
   assign w_vec_nxt = w_load0 ? 2'd0 : r_vec_idx + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_load0    = 1'b0;
      w_clr_cnt  = 1'b0;
      w_adv      = 1'b0;
      w_gap_load = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_clr_cnt = 1'b1;
               if (SEND_ANY) begin
                  w_next  = S_SEND;
                  w_load0 = 1'b1;
               end else begin
                  w_next = S_DONE;
               end
            end
         end
         S_SEND: begin
            if (w_xfer) begin
               if (w_last) begin
                  w_next = S_DONE;
               end else if (USE_GAP) begin
                  w_next     = S_GAP;
                  w_gap_load = 1'b1;
               end else begin
                  w_adv = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (w_gap_tc) begin
               w_next = S_SEND;
               w_adv  = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Expected results are registered alongside the operands so that every
   // output, including exp_not_a, reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sent_cnt  <= '0;
         r_vec_idx   <= '0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_exp_and   <= 1'b0;
         r_exp_or    <= 1'b0;
         r_exp_not_a <= 1'b0;
         r_sweep     <= '0;
         r_gap_cnt   <= '0;
      end else begin
         if (w_clr_cnt)
            r_sent_cnt <= '0;
         else if (w_xfer && (r_sent_cnt != 16'hFFFF))
            r_sent_cnt <= r_sent_cnt + 16'd1;

         if (w_load0 || w_adv) begin
            r_vec_idx   <= w_vec_nxt;
            r_a         <= w_vec_nxt[1];
            r_b         <= w_vec_nxt[0];
            r_exp_and   <= &w_vec_nxt;
            r_exp_or    <= |w_vec_nxt;
            r_exp_not_a <= ~w_vec_nxt[1];
         end

         if (w_load0)
            r_sweep <= '0;
         else if (w_adv && (r_vec_idx == 2'd3))
            r_sweep <= r_sweep + SW_ONE;

         if (w_gap_load)
            r_gap_cnt <= GAP_LOAD;
         else if (r_state == S_GAP)
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
      end
   end

   assign out_valid = (r_state == S_SEND);
   assign busy      = (r_state == S_SEND) || (r_state == S_GAP);
   assign done      = (r_state == S_DONE);
   assign a         = r_a;
   assign b         = r_b;
   assign exp_and   = r_exp_and;
   assign exp_or    = r_exp_or;
   assign exp_not_a = r_exp_not_a;
   assign vec_idx   = r_vec_idx;
   assign sent_cnt  = r_sent_cnt;

endmodule

// File: tb/tb_bool_vector_tx.sv
// Bench for bool_vector_tx: four instances with different REPEAT/GAP, a
// transfer-count model checked every cycle, plus directed literal checks.
module tb_bool_vector_tx;

   logic        clk;
   logic        rst_n;
   logic [3:0]  t_start;
   logic [3:0]  t_ready;
   logic [3:0]  d_valid, d_a, d_b, d_and, d_or, d_nota, d_busy, d_done;
   logic [1:0]  d_vec [4];
   logic [15:0] d_cnt [4];

   int n_cmp = 0;
   int n_err = 0;

   bool_vector_tx #(.REPEAT(1), .GAP(0)) u_r1g0 (
      .clk(clk), .rst_n(rst_n), .start(t_start[0]), .out_valid(d_valid[0]),
      .out_ready(t_ready[0]), .a(d_a[0]), .b(d_b[0]), .exp_and(d_and[0]),
      .exp_or(d_or[0]), .exp_not_a(d_nota[0]), .vec_idx(d_vec[0]),
      .sent_cnt(d_cnt[0]), .busy(d_busy[0]), .done(d_done[0]));

   bool_vector_tx #(.REPEAT(2), .GAP(0)) u_r2g0 (
      .clk(clk), .rst_n(rst_n), .start(t_start[1]), .out_valid(d_valid[1]),
      .out_ready(t_ready[1]), .a(d_a[1]), .b(d_b[1]), .exp_and(d_and[1]),
      .exp_or(d_or[1]), .exp_not_a(d_nota[1]), .vec_idx(d_vec[1]),
      .sent_cnt(d_cnt[1]), .busy(d_busy[1]), .done(d_done[1]));

   bool_vector_tx #(.REPEAT(1), .GAP(2)) u_r1g2 (
      .clk(clk), .rst_n(rst_n), .start(t_start[2]), .out_valid(d_valid[2]),
      .out_ready(t_ready[2]), .a(d_a[2]), .b(d_b[2]), .exp_and(d_and[2]),
      .exp_or(d_or[2]), .exp_not_a(d_nota[2]), .vec_idx(d_vec[2]),
      .sent_cnt(d_cnt[2]), .busy(d_busy[2]), .done(d_done[2]));

   bool_vector_tx #(.REPEAT(0), .GAP(0)) u_r0g0 (
      .clk(clk), .rst_n(rst_n), .start(t_start[3]), .out_valid(d_valid[3]),
      .out_ready(t_ready[3]), .a(d_a[3]), .b(d_b[3]), .exp_and(d_and[3]),
      .exp_or(d_or[3]), .exp_not_a(d_nota[3]), .vec_idx(d_vec[3]),
      .sent_cnt(d_cnt[3]), .busy(d_busy[3]), .done(d_done[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int rep_of(input int i);
      case (i)
         0: return 1;
         1: return 2;
         2: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int gap_of(input int i);
      return (i == 2) ? 2 : 0;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a run is REPEAT*4 accepted transfers; after each non-final
   // transfer, GAP invalid cycles precede the next vector.
   int m_act[4], m_valid[4], m_done[4], m_vec[4], m_cnt[4], m_n[4], m_gap[4], m_ld[4];
   int x_act[4], x_valid[4], x_done[4], x_vec[4], x_cnt[4], x_n[4], x_gap[4], x_ld[4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         x_act[i]   = m_act[i];
         x_valid[i] = m_valid[i];
         x_done[i]  = m_done[i];
         x_vec[i]   = m_vec[i];
         x_cnt[i]   = m_cnt[i];
         x_n[i]     = m_n[i];
         x_gap[i]   = m_gap[i];
         x_ld[i]    = m_ld[i];
         if (m_act[i] == 0) begin
            if (t_start[i]) begin
               x_cnt[i] = 0;
               if (rep_of(i) > 0) begin
                  x_act[i]   = 1;
                  x_valid[i] = 1;
                  x_done[i]  = 0;
                  x_vec[i]   = 0;
                  x_n[i]     = 0;
                  x_ld[i]    = 1;
               end else begin
                  x_done[i] = 1;
               end
            end
         end else if (m_valid[i] == 1) begin
            if (t_ready[i]) begin
               x_cnt[i] = (m_cnt[i] < 65535) ? m_cnt[i] + 1 : 65535;
               x_n[i]   = m_n[i] + 1;
               if (m_n[i] + 1 == 4 * rep_of(i)) begin
                  x_act[i]   = 0;
                  x_valid[i] = 0;
                  x_done[i]  = 1;
               end else if (gap_of(i) > 0) begin
                  x_valid[i] = 0;
                  x_gap[i]   = gap_of(i);
               end else begin
                  x_vec[i] = (m_vec[i] + 1) % 4;
               end
            end
         end else begin
            x_gap[i] = m_gap[i] - 1;
            if (m_gap[i] - 1 == 0) begin
               x_valid[i] = 1;
               x_vec[i]   = (m_vec[i] + 1) % 4;
            end
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 4; i++) begin
         if (!rst_n) begin
            m_act[i] <= 0; m_valid[i] <= 0; m_done[i] <= 0; m_vec[i] <= 0;
            m_cnt[i] <= 0; m_n[i] <= 0; m_gap[i] <= 0; m_ld[i] <= 0;
         end else begin
            m_act[i] <= x_act[i]; m_valid[i] <= x_valid[i]; m_done[i] <= x_done[i];
            m_vec[i] <= x_vec[i]; m_cnt[i] <= x_cnt[i]; m_n[i] <= x_n[i];
            m_gap[i] <= x_gap[i]; m_ld[i] <= x_ld[i];
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         check($sformatf("valid[%0d]", i), int'(d_valid[i]), m_valid[i]);
         check($sformatf("busy[%0d]", i), int'(d_busy[i]), m_act[i]);
         check($sformatf("done[%0d]", i), int'(d_done[i]), m_done[i]);
         check($sformatf("vec_idx[%0d]", i), int'(d_vec[i]), m_vec[i]);
         check($sformatf("a[%0d]", i), int'(d_a[i]), m_vec[i] / 2);
         check($sformatf("b[%0d]", i), int'(d_b[i]), m_vec[i] % 2);
         check($sformatf("exp_and[%0d]", i), int'(d_and[i]), int'(m_vec[i] == 3));
         check($sformatf("exp_or[%0d]", i), int'(d_or[i]), int'(m_vec[i] != 0));
         check($sformatf("exp_not_a[%0d]", i), int'(d_nota[i]), int'(m_ld[i] != 0 && m_vec[i] < 2));
         check($sformatf("sent_cnt[%0d]", i), int'(d_cnt[i]), m_cnt[i]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [3:0] lit_a, lit_b, lit_and, lit_or, lit_nota;
   logic [9:0] lit_pat;
   int         prev_cnt;

   initial begin
      lit_a    = 4'b1100;
      lit_b    = 4'b1010;
      lit_and  = 4'b1000;
      lit_or   = 4'b1110;
      lit_nota = 4'b0011;
      lit_pat  = 10'b1001001001;
      rst_n    = 1'b0;
      t_start  = 4'b0000;
      t_ready  = 4'b1111;
      #22 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_valid[%0d]", i), int'(d_valid[i]), 0);
         check($sformatf("rst_nota[%0d]", i), int'(d_nota[i]), 0);
         check($sformatf("rst_cnt[%0d]", i), int'(d_cnt[i]), 0);
      end

      // Single sweep, back-to-back
      t_start[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) t_start[0] = 1'b0;
         check($sformatf("t1_valid%0d", k), int'(d_valid[0]), 1);
         check($sformatf("t1_a%0d", k), int'(d_a[0]), int'(lit_a[k]));
         check($sformatf("t1_b%0d", k), int'(d_b[0]), int'(lit_b[k]));
         check($sformatf("t1_and%0d", k), int'(d_and[0]), int'(lit_and[k]));
         check($sformatf("t1_or%0d", k), int'(d_or[0]), int'(lit_or[k]));
         check($sformatf("t1_nota%0d", k), int'(d_nota[0]), int'(lit_nota[k]));
      end
      @(negedge clk);
      check("t1_done", int'(d_done[0]), 1);
      check("t1_cnt", int'(d_cnt[0]), 4);

      // Backpressure on vector 1
      t_start[1] = 1'b1;
      @(negedge clk);
      t_start[1] = 1'b0;
      @(negedge clk);
      t_ready[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("t2_hold_valid%0d", k), int'(d_valid[1]), 1);
         check($sformatf("t2_hold_a%0d", k), int'(d_a[1]), 0);
         check($sformatf("t2_hold_b%0d", k), int'(d_b[1]), 1);
      end
      t_ready[1] = 1'b1;
      for (int k = 0; k < 50 && !d_done[1]; k++) @(negedge clk);
      check("t2_done", int'(d_done[1]), 1);
      check("t2_cnt", int'(d_cnt[1]), 8);

      // Gap spacing
      t_start[2] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) t_start[2] = 1'b0;
         check($sformatf("t3_valid%0d", k), int'(d_valid[2]), int'(lit_pat[k]));
      end
      @(negedge clk);
      check("t3_done", int'(d_done[2]), 1);
      check("t3_cnt", int'(d_cnt[2]), 4);

      // Empty run
      t_start[3] = 1'b1;
      @(negedge clk);
      t_start[3] = 1'b0;
      check("t4_done", int'(d_done[3]), 1);
      check("t4_cnt", int'(d_cnt[3]), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("t4_valid%0d", k), int'(d_valid[3]), 0);
      end

      // Reset mid-run after two transfers
      t_start[1] = 1'b1;
      @(negedge clk);
      t_start[1] = 1'b0;
      check("t5_restart_cnt", int'(d_cnt[1]), 0);
      @(negedge clk);
      @(negedge clk);
      check("t5_pre_cnt", int'(d_cnt[1]), 2);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_valid", int'(d_valid[1]), 0);
      check("t5_async_cnt", int'(d_cnt[1]), 0);
      check("t5_async_vec", int'(d_vec[1]), 0);
      check("t5_async_busy", int'(d_busy[1]), 0);
      check("t5_async_nota", int'(d_nota[1]), 0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("t5_idle_valid%0d", k), int'(d_valid[1]), 0);
         check($sformatf("t5_idle_done%0d", k), int'(d_done[1]), 0);
      end

      // Start held through the run, then restart from DONE
      t_start[1] = 1'b1;
      @(negedge clk);
      check("t6_first_valid", int'(d_valid[1]), 1);
      check("t6_first_vec", int'(d_vec[1]), 0);
      prev_cnt = int'(d_cnt[1]);
      for (int k = 0; k < 50 && !d_done[1]; k++) begin
         @(negedge clk);
         check($sformatf("t6_mono%0d", k), int'(int'(d_cnt[1]) >= prev_cnt), 1);
         prev_cnt = int'(d_cnt[1]);
      end
      check("t6_done", int'(d_done[1]), 1);
      check("t6_cnt", int'(d_cnt[1]), 8);
      @(negedge clk);
      t_start[1] = 1'b0;
      check("t6_re_cnt", int'(d_cnt[1]), 0);
      check("t6_re_vec", int'(d_vec[1]), 0);
      check("t6_re_valid", int'(d_valid[1]), 1);
      for (int k = 0; k < 50 && !d_done[1]; k++) @(negedge clk);
      check("t6_end_cnt", int'(d_cnt[1]), 8);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
